tank_ctrl: RTL

TANK_CTRL -- requirements
Module: tank_ctrl

---
 rtl/tank_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tank_ctrl.sv
// Tank level controller: fills the tank, arbitrates two consumers round-robin with a
// hold limit, and latches a fault after a run of consecutive tank-model errors.
module tank_ctrl #(
  parameter logic [7:0] LOW_MARK    = 8'd40,
  parameter logic [7:0] HIGH_MARK   = 8'd90,
  parameter int         GRANT_LEN   = 4,
  parameter int         FAULT_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] height,
  input  logic       error,
  input  logic [1:0] req,
  input  logic       clr_fault,
  output logic       fill,
  output logic       consume,
  output logic [1:0] grant,
  output logic [1:0] state,
  output logic       fault
);

  // state | meaning
  // INIT  | initial fill until height reaches LOW_MARK
  // FILL  | consumers starved, refill until HIGH_MARK
  // SERVE | arbitrate consumers, top up below HIGH_MARK
  // FAULT | everything off until cleared with error low
  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_FILL  = 2'b01,
    ST_SERVE = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [2:0] GLEN_LOAD = 3'(GRANT_LEN - 1);
  localparam logic [2:0] FLIMIT    = 3'(FAULT_LIMIT);

  state_t     state_q, state_d;
  logic       fill_q, fill_d;
  logic       consume_q, consume_d;
  logic [1:0] grant_q, grant_d;
  logic       fault_q, fault_d;
  logic       rr_q, rr_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [2:0] gcnt_q, gcnt_d;

  logic [2:0] fcnt_inc;
  logic       counting;
  logic       fault_trip;
  logic       held;
  logic       other;
  logic       pick;

  always_comb begin
    fcnt_inc   = (fcnt_q == 3'd7) ? 3'd7 : fcnt_q + 3'd1;
    counting   = (state_q == ST_FILL) || (state_q == ST_SERVE);
    fault_trip = counting && error && (fcnt_inc >= FLIMIT);
    held       = grant_q[1];
    other      = ~held;
    pick       = req[rr_q] ? rr_q : ~rr_q;

    state_d = state_q;
    fill_d  = fill_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    gcnt_d  = gcnt_q;
    fcnt_d  = counting ? (error ? fcnt_inc : 3'd0) : 3'd0;

    case (state_q)
      ST_INIT: begin
        fill_d  = 1'b1;
        grant_d = 2'b00;
        if (height >= LOW_MARK && !error) begin
          state_d = ST_SERVE;
          fill_d  = (height < HIGH_MARK);
        end
      end
      ST_FILL: begin
        fill_d  = 1'b1;
        grant_d = 2'b00;
        if (fault_trip) begin
          state_d = ST_FAULT;
          fill_d  = 1'b0;
        end else if (height >= HIGH_MARK && !error) begin
          state_d = ST_SERVE;
          fill_d  = 1'b0;
        end
      end
      ST_SERVE: begin
        fill_d = (height < HIGH_MARK);
        if (fault_trip || height < LOW_MARK) begin
          state_d = fault_trip ? ST_FAULT : ST_FILL;
          fill_d  = !fault_trip;
          grant_d = 2'b00;
          gcnt_d  = 3'd0;
          if (grant_q != 2'b00) rr_d = other;
        end else if (grant_q != 2'b00) begin
          // Release hands straight over when the other consumer is waiting.
          if (!req[held] || gcnt_q == 3'd0) begin
            rr_d = other;
            if (req[other]) begin
              grant_d = other ? 2'b10 : 2'b01;
              gcnt_d  = GLEN_LOAD;
            end else begin
              grant_d = 2'b00;
              gcnt_d  = 3'd0;
            end
          end else begin
            gcnt_d = gcnt_q - 3'd1;
          end
        end else if (req != 2'b00) begin
          grant_d = pick ? 2'b10 : 2'b01;
          gcnt_d  = GLEN_LOAD;
        end
      end
      ST_FAULT: begin
        fill_d  = 1'b0;
        grant_d = 2'b00;
        gcnt_d  = 3'd0;
        if (clr_fault && !error) begin
          state_d = ST_INIT;
          fill_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        grant_d = 2'b00;
      end
    endcase

    consume_d = |grant_d;
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      fill_q    <= 1'b0;
      consume_q <= 1'b0;
      grant_q   <= 2'b00;
      fault_q   <= 1'b0;
      rr_q      <= 1'b0;
      fcnt_q    <= 3'd0;
      gcnt_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      consume_q <= consume_d;
      grant_q   <= grant_d;
      fault_q   <= fault_d;
      rr_q      <= rr_d;
      fcnt_q    <= fcnt_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign fill    = fill_q;
  assign consume = consume_q;
  assign grant   = grant_q;
  assign state   = state_q;
  assign fault   = fault_q;

endmodule
